// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU widths, zero-register index and load-size encodings
package cpu_pkg;
    localparam int DATA_W = 64;
    localparam int REG_AW = 5;
    localparam logic [REG_AW-1:0] ZERO_REG = 5'd31;

    typedef enum logic [1:0] {
        LS_BYTE  = 2'd0,
        LS_HALF  = 2'd1,
        LS_WORD  = 2'd2,
        LS_DWORD = 2'd3
    } load_size_t;
endpackage

// File: rtl/write_back_stage_if.sv
// rtl/write_back_stage_if.sv - MEM->WB inputs and register-file write port; WB_FWD_EN adds bypass signals
interface write_back_stage_if;
    import cpu_pkg::*;

    logic              valid_i;
    logic [REG_AW-1:0] dest_reg_i;
    logic [DATA_W-1:0] mem_data_i;
    logic [DATA_W-1:0] alu_result_i;
    logic              mem_to_reg_i;
    logic              reg_write_i;
    logic [1:0]        load_size_i;
    logic              load_signed_i;
    logic [DATA_W-1:0] wr_data_o;
    logic [REG_AW-1:0] wr_reg_o;
    logic              wr_en_o;
`ifdef WB_FWD_EN
    logic              fwd_en_o;
    logic [REG_AW-1:0] fwd_reg_o;
    logic [DATA_W-1:0] fwd_data_o;

    modport slave (
        input  valid_i, dest_reg_i, mem_data_i, alu_result_i,
        input  mem_to_reg_i, reg_write_i, load_size_i, load_signed_i,
        output wr_data_o, wr_reg_o, wr_en_o,
        output fwd_en_o, fwd_reg_o, fwd_data_o
    );
    modport master (
        output valid_i, dest_reg_i, mem_data_i, alu_result_i,
        output mem_to_reg_i, reg_write_i, load_size_i, load_signed_i,
        input  wr_data_o, wr_reg_o, wr_en_o,
        input  fwd_en_o, fwd_reg_o, fwd_data_o
    );
`else
    modport slave (
        input  valid_i, dest_reg_i, mem_data_i, alu_result_i,
        input  mem_to_reg_i, reg_write_i, load_size_i, load_signed_i,
        output wr_data_o, wr_reg_o, wr_en_o
    );
    modport master (
        output valid_i, dest_reg_i, mem_data_i, alu_result_i,
        output mem_to_reg_i, reg_write_i, load_size_i, load_signed_i,
        input  wr_data_o, wr_reg_o, wr_en_o
    );
`endif
endinterface

// File: rtl/write_back_stage_load_extend.sv
// rtl/write_back_stage_load_extend.sv - load_extend: size select and sign/zero extension of loaded data
module load_extend
    import cpu_pkg::*;
(
    input  logic [DATA_W-1:0] i_data,
    input  load_size_t        i_size,
    input  logic              i_signed,
    output logic [DATA_W-1:0] o_data
);
    logic w_fill;

    always_comb begin
        w_fill = 1'b0;
        o_data = i_data;
        case (i_size)
            LS_BYTE: begin
                w_fill = i_signed & i_data[7];
                o_data = {{(DATA_W-8){w_fill}}, i_data[7:0]};
            end
            LS_HALF: begin
                w_fill = i_signed & i_data[15];
                o_data = {{(DATA_W-16){w_fill}}, i_data[15:0]};
            end
            LS_WORD: begin
                w_fill = i_signed & i_data[31];
                o_data = {{(DATA_W-32){w_fill}}, i_data[31:0]};
            end
            default: o_data = i_data;
        endcase
    end
endmodule

// File: rtl/write_back_stage.sv
// rtl/write_back_stage.sv - WB stage: selects/extends commit data into a registered write port; WB_FWD_EN adds same-cycle bypass
module write_back_stage
    import cpu_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    write_back_stage_if.slave   bus
);
    logic [DATA_W-1:0] w_ext;
    logic [DATA_W-1:0] w_sel;
    logic              w_wr_en_next;

    logic [DATA_W-1:0] r_wr_data;
    logic [REG_AW-1:0] r_wr_reg;
    logic              r_wr_en;

    load_extend u_load_extend (
        .i_data   (bus.mem_data_i),
        .i_size   (load_size_t'(bus.load_size_i)),
        .i_signed (bus.load_signed_i),
        .o_data   (w_ext)
    );

    assign w_sel        = bus.mem_to_reg_i ? w_ext : bus.alu_result_i;
    assign w_wr_en_next = bus.valid_i & bus.reg_write_i & (bus.dest_reg_i != ZERO_REG);

    // Data and index follow the inputs even when no write happens; wr_en_o qualifies them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_data <= '0;
            r_wr_reg  <= '0;
            r_wr_en   <= 1'b0;
        end else begin
            r_wr_data <= w_sel;
            r_wr_reg  <= bus.dest_reg_i;
            r_wr_en   <= w_wr_en_next;
        end
    end

    assign bus.wr_data_o = r_wr_data;
    assign bus.wr_reg_o  = r_wr_reg;
    assign bus.wr_en_o   = r_wr_en;

`ifdef WB_FWD_EN
    assign bus.fwd_en_o   = w_wr_en_next & ~rst;
    assign bus.fwd_reg_o  = bus.dest_reg_i;
    assign bus.fwd_data_o = w_sel;
`endif
endmodule

// File: tb/tb_write_back_stage.sv
// tb/tb_write_back_stage.sv - scoreboard bench for write_back_stage (also covers WB_FWD_EN builds)
module tb_write_back_stage;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    write_back_stage_if wb_if ();

    write_back_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (wb_if.slave)
    );

    typedef struct {
        string             tag;
        logic              en;
        logic [REG_AW-1:0] rg;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    localparam logic [63:0] MEMV = 64'h1234_5678_9ABC_80F0;

    function automatic logic [63:0] model(input logic [63:0] mem, input logic [63:0] alu,
                                          input logic m2r, input logic [1:0] ls, input logic sg);
        logic [63:0] v;
        int          sh;
        sh = 64 - (8 << ls);
        v  = mem << sh;
        v  = sg ? 64'($signed(v) >>> sh) : (v >> sh);
        return m2r ? v : alu;
    endfunction

    task automatic check_out();
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_vec++;
            assert (wb_if.wr_en_o === e.en) else begin
                n_err++;
                $error("FAIL %s wr_en_o observed=%0b expected=%0b", e.tag, wb_if.wr_en_o, e.en);
            end
            n_vec++;
            assert (wb_if.wr_reg_o === e.rg) else begin
                n_err++;
                $error("FAIL %s wr_reg_o observed=%0d expected=%0d", e.tag, wb_if.wr_reg_o, e.rg);
            end
            n_vec++;
            assert (wb_if.wr_data_o === e.data) else begin
                n_err++;
                $error("FAIL %s wr_data_o observed=%h expected=%h", e.tag, wb_if.wr_data_o, e.data);
            end
        end
    endtask

    task automatic drive(input string tag, input logic r, input logic v, input logic rw,
                         input logic m2r, input logic [1:0] ls, input logic sg,
                         input logic [4:0] d, input logic [63:0] mem, input logic [63:0] alu,
                         input logic [63:0] exp_data);
        exp_t e;
        logic en_n;
        @(negedge clk);
        check_out();
        rst                 = r;
        wb_if.valid_i       = v;
        wb_if.reg_write_i   = rw;
        wb_if.mem_to_reg_i  = m2r;
        wb_if.load_size_i   = ls;
        wb_if.load_signed_i = sg;
        wb_if.dest_reg_i    = d;
        wb_if.mem_data_i    = mem;
        wb_if.alu_result_i  = alu;
        en_n   = v & rw & (d != 5'd31);
        e.tag  = tag;
        e.en   = r ? 1'b0 : en_n;
        e.rg   = r ? 5'd0 : d;
        e.data = r ? 64'd0 : exp_data;
        sb.push_back(e);
`ifdef WB_FWD_EN
        #1;
        n_vec++;
        assert (wb_if.fwd_en_o === (r ? 1'b0 : en_n)) else begin
            n_err++;
            $error("FAIL %s fwd_en_o observed=%0b expected=%0b", tag, wb_if.fwd_en_o, r ? 1'b0 : en_n);
        end
        n_vec++;
        assert (wb_if.fwd_reg_o === d) else begin
            n_err++;
            $error("FAIL %s fwd_reg_o observed=%0d expected=%0d", tag, wb_if.fwd_reg_o, d);
        end
        n_vec++;
        assert (wb_if.fwd_data_o === exp_data) else begin
            n_err++;
            $error("FAIL %s fwd_data_o observed=%h expected=%h", tag, wb_if.fwd_data_o, exp_data);
        end
`endif
    endtask

    initial begin
        logic [63:0] m, a;
        logic [1:0]  ls;
        logic        sg, m2r, v, rw;
        logic [4:0]  d;

        // Reset held with a live instruction: outputs must stay cleared.
        drive("rst0", 1, 1, 1, 0, 2'd0, 0, 5'd5, 64'd0, 64'd0, 64'd0);
        drive("rst1", 1, 1, 1, 0, 2'd0, 0, 5'd5, 64'd0, 64'd0, 64'd0);
        drive("rst_rel", 0, 1, 1, 0, 2'd0, 0, 5'd5, 64'd0, 64'd0, 64'd0);

        drive("alu", 0, 1, 1, 0, 2'd0, 0, 5'd3, 64'd0, 64'h0000_0000_DEAD_BEEF, 64'h0000_0000_DEAD_BEEF);

        drive("ld_b_s", 0, 1, 1, 1, 2'd0, 1, 5'd4, MEMV, 64'h77, 64'hFFFF_FFFF_FFFF_FFF0);
        drive("ld_b_u", 0, 1, 1, 1, 2'd0, 0, 5'd4, MEMV, 64'h77, 64'h0000_0000_0000_00F0);
        drive("ld_h_s", 0, 1, 1, 1, 2'd1, 1, 5'd4, MEMV, 64'h77, 64'hFFFF_FFFF_FFFF_80F0);
        drive("ld_w_u", 0, 1, 1, 1, 2'd2, 0, 5'd4, MEMV, 64'h77, 64'h0000_0000_9ABC_80F0);
        drive("ld_w_s", 0, 1, 1, 1, 2'd2, 1, 5'd4, MEMV, 64'h77, 64'hFFFF_FFFF_9ABC_80F0);
        drive("ld_d_s", 0, 1, 1, 1, 2'd3, 1, 5'd4, MEMV, 64'h77, MEMV);
        drive("ld_d_u", 0, 1, 1, 1, 2'd3, 0, 5'd4, MEMV, 64'h77, MEMV);

        drive("xzr", 0, 1, 1, 0, 2'd0, 0, 5'd31, 64'd0, 64'h11, 64'h11);
        drive("x30", 0, 1, 1, 0, 2'd0, 0, 5'd30, 64'd0, 64'h22, 64'h22);

        drive("bubble", 0, 0, 1, 0, 2'd0, 0, 5'd7, 64'd0, 64'h99, 64'h99);
        drive("ld_nowr", 0, 1, 0, 1, 2'd3, 0, 5'd8, MEMV, 64'h0, MEMV);
        drive("b2b1", 0, 1, 1, 0, 2'd0, 0, 5'd7, 64'd0, 64'd1, 64'd1);
        drive("b2b2", 0, 1, 1, 0, 2'd0, 0, 5'd7, 64'd0, 64'd2, 64'd2);
        drive("b2b3", 0, 1, 1, 0, 2'd0, 0, 5'd7, 64'd0, 64'd3, 64'd3);

        drive("fwd9", 0, 1, 1, 0, 2'd0, 0, 5'd9, 64'd0, 64'h55, 64'h55);

        for (int i = 0; i < 24; i++) begin
            m   = {$urandom, $urandom};
            a   = {$urandom, $urandom};
            ls  = 2'($urandom_range(0, 3));
            sg  = 1'($urandom_range(0, 1));
            m2r = 1'($urandom_range(0, 1));
            v   = 1'($urandom_range(0, 3) != 0);
            rw  = 1'($urandom_range(0, 3) != 0);
            d   = 5'($urandom_range(28, 31));
            drive("rand", 0, v, rw, m2r, ls, sg, d, m, a, model(m, a, m2r, ls, sg));
        end

        drive("rst_mid", 1, 1, 1, 1, 2'd0, 1, 5'd6, MEMV, 64'h1, 64'hFFFF_FFFF_FFFF_FFF0);
        drive("idle", 0, 0, 0, 0, 2'd0, 0, 5'd0, 64'd0, 64'd0, 64'd0);

        for (int k = 0; k < 4 && sb.size() > 0; k++) begin
            @(negedge clk);
            check_out();
        end
        n_vec++;
        assert (sb.size() == 0) else begin
            n_err++;
            $error("FAIL drain pending observed=%0d expected=0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
